// File: rtl/scan_unload_pkg.sv
// Shared definitions for the scan-unload MISR block: FSM state encoding and
// default MISR polynomial/seed values.
package scan_unload_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SHIFT   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam logic [15:0] DEF_MISR_POLY = 16'h1021;
    localparam logic [15:0] DEF_MISR_SEED = 16'h0000;

endpackage : scan_unload_pkg

// File: rtl/misr_step.sv
// One combinational MISR step: shift left, fold the polynomial in when the
// MSB falls out, and XOR chain i's scan-out bit into signature bit i.
module misr_step #(
    parameter int                NUM_CHAINS = 4,
    parameter int                MISR_W     = 16,
    parameter logic [MISR_W-1:0] MISR_POLY  = {MISR_W{1'b0}}
) (
    input  logic [MISR_W-1:0]     sig,
    input  logic [NUM_CHAINS-1:0] so,
    output logic [MISR_W-1:0]     sig_next
);

    logic [MISR_W-1:0] so_ext_s;
    logic [MISR_W-1:0] fb_s;

    // Next-signature computation
    always_comb begin
        so_ext_s                   = {MISR_W{1'b0}};
        so_ext_s[NUM_CHAINS-1:0]   = so;
        if (sig[MISR_W-1]) begin
            fb_s = MISR_POLY;
        end else begin
            fb_s = {MISR_W{1'b0}};
        end
        sig_next = {sig[MISR_W-2:0], 1'b0} ^ fb_s ^ so_ext_s;
    end

endmodule : misr_step

// File: rtl/scan_unload_misr.sv
// Scan-unload controller: drives SE, compacts NUM_CHAINS scan-out streams into a
// MISR over PAT_NUM patterns. Optional comparator: SCAN_UNLOAD_MISR_COMPARE_EN.
module scan_unload_misr
    import scan_unload_pkg::*;
#(
    parameter int                NUM_CHAINS = 4,
    parameter int                CHAIN_LEN  = 16,
    parameter int                MISR_W     = 16,
    parameter logic [MISR_W-1:0] MISR_POLY  = MISR_W'(DEF_MISR_POLY),
    parameter logic [MISR_W-1:0] MISR_SEED  = MISR_W'(DEF_MISR_SEED)
) (
    input  logic                  CK,
    input  logic                  RESETN,
    input  logic                  START,
    input  logic [7:0]            PAT_NUM,
    input  logic [NUM_CHAINS-1:0] SO,
`ifdef SCAN_UNLOAD_MISR_COMPARE_EN
    input  logic [MISR_W-1:0]     EXP_SIG,
    output logic                  PASS,
`endif
    output logic                  SE,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [MISR_W-1:0]     SIGNATURE
);

    localparam int BIT_CNT_W = $clog2(CHAIN_LEN + 1);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(CHAIN_LEN - 1);

    if ((NUM_CHAINS < 1) || (NUM_CHAINS > MISR_W) || (MISR_W < 2) || (CHAIN_LEN < 1)) begin : g_bad_cfg
        $error("scan_unload_misr: illegal NUM_CHAINS/MISR_W/CHAIN_LEN combination");
    end

    state_t                 state_r;
    state_t                 next_state_s;
    logic [BIT_CNT_W-1:0]   bit_cnt_r;
    logic [7:0]             pat_cnt_r;
    logic [MISR_W-1:0]      sig_r;
    logic [MISR_W-1:0]      sig_next_s;
    logic [MISR_W-1:0]      sig_d_s;
    logic                   last_bit_s;
    logic                   se_d_s;
    logic                   busy_d_s;
    logic                   done_d_s;
    logic                   se_r;
    logic                   busy_r;
    logic                   done_r;

    misr_step #(
        .NUM_CHAINS (NUM_CHAINS),
        .MISR_W     (MISR_W),
        .MISR_POLY  (MISR_POLY)
    ) u_misr_step (
        .sig      (sig_r),
        .so       (SO),
        .sig_next (sig_next_s)
    );

    assign last_bit_s = (bit_cnt_r == LAST_BIT);

    // State and output registers
    always_ff @(posedge CK or negedge RESETN) begin
        if (!RESETN) begin
            state_r <= ST_IDLE;
            se_r    <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            se_r    <= se_d_s;
            busy_r  <= busy_d_s;
            done_r  <= done_d_s;
        end
    end

    // Next-state decode
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (START) begin
                    if (PAT_NUM == 8'd0) begin
                        next_state_s = ST_DONE;
                    end else begin
                        next_state_s = ST_SHIFT;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (last_bit_s) begin
                    if (pat_cnt_r == 8'd1) begin
                        next_state_s = ST_DONE;
                    end else begin
                        next_state_s = ST_CAPTURE;
                    end
                end else begin
                    next_state_s = ST_SHIFT;
                end
            end
            ST_CAPTURE: next_state_s = ST_SHIFT;
            ST_DONE:    next_state_s = ST_IDLE;
            default:    next_state_s = ST_IDLE;
        endcase
    end

    // Output decode from the upcoming state so every output comes straight off a flop
    always_comb begin
        se_d_s   = 1'b0;
        busy_d_s = 1'b0;
        done_d_s = 1'b0;
        case (next_state_s)
            ST_SHIFT: begin
                se_d_s   = 1'b1;
                busy_d_s = 1'b1;
            end
            ST_CAPTURE: busy_d_s = 1'b1;
            ST_DONE:    done_d_s = 1'b1;
            ST_IDLE:    done_d_s = 1'b0;
            default:    done_d_s = 1'b0;
        endcase
    end

    // Signature next value: seed on accepted START, compact only while shifting
    always_comb begin
        sig_d_s = sig_r;
        case (state_r)
            ST_IDLE: begin
                if (START) begin
                    sig_d_s = MISR_SEED;
                end else begin
                    sig_d_s = sig_r;
                end
            end
            ST_SHIFT: sig_d_s = sig_next_s;
            default:  sig_d_s = sig_r;
        endcase
    end

    // Datapath registers: signature, shift-bit counter, remaining-pattern counter
    always_ff @(posedge CK or negedge RESETN) begin
        if (!RESETN) begin
            sig_r     <= MISR_SEED;
            bit_cnt_r <= {BIT_CNT_W{1'b0}};
            pat_cnt_r <= 8'd0;
        end else begin
            sig_r <= sig_d_s;
            case (state_r)
                ST_IDLE: begin
                    if (START) begin
                        pat_cnt_r <= PAT_NUM;
                        bit_cnt_r <= {BIT_CNT_W{1'b0}};
                    end else begin
                        pat_cnt_r <= pat_cnt_r;
                    end
                end
                ST_SHIFT: begin
                    bit_cnt_r <= bit_cnt_r + BIT_CNT_W'(1);
                    if (last_bit_s) begin
                        pat_cnt_r <= pat_cnt_r - 8'd1;
                    end else begin
                        pat_cnt_r <= pat_cnt_r;
                    end
                end
                ST_CAPTURE: bit_cnt_r <= {BIT_CNT_W{1'b0}};
                default:    bit_cnt_r <= bit_cnt_r;
            endcase
        end
    end

`ifdef SCAN_UNLOAD_MISR_COMPARE_EN
    logic pass_r;

    // Compare result captured on entry to DONE; a fresh START clears it
    always_ff @(posedge CK or negedge RESETN) begin
        if (!RESETN) begin
            pass_r <= 1'b0;
        end else if ((next_state_s == ST_DONE) && (state_r != ST_DONE)) begin
            pass_r <= (sig_d_s == EXP_SIG);
        end else if ((state_r == ST_IDLE) && START) begin
            pass_r <= 1'b0;
        end else begin
            pass_r <= pass_r;
        end
    end

    assign PASS = pass_r;
`endif

    assign SE        = se_r;
    assign BUSY      = busy_r;
    assign DONE      = done_r;
    assign SIGNATURE = sig_r;

endmodule : scan_unload_misr

// File: tb/tb_scan_unload_misr.sv
// Directed bench for scan_unload_misr (1 chain, 4 flops, 4-bit MISR, poly 4'h3).
// Define SCAN_UNLOAD_MISR_COMPARE_EN to also exercise the PASS comparator.
module tb_scan_unload_misr;

    logic       CK = 1'b0;
    logic       RESETN;
    logic       START;
    logic [7:0] PAT_NUM;
    logic [0:0] SO;
    logic       SE;
    logic       BUSY;
    logic       DONE;
    logic [3:0] SIGNATURE;
`ifdef SCAN_UNLOAD_MISR_COMPARE_EN
    logic [3:0] EXP_SIG;
    logic       PASS;
`endif

    int checks   = 0;
    int failures = 0;

    int          done_cyc;
    int          busy_cyc;
    logic [31:0] se_trace;
    logic        pass_first;
    logic        pass_done;

    scan_unload_misr #(
        .NUM_CHAINS (1),
        .CHAIN_LEN  (4),
        .MISR_W     (4),
        .MISR_POLY  (4'h3),
        .MISR_SEED  (4'h0)
    ) dut (
        .CK        (CK),
        .RESETN    (RESETN),
        .START     (START),
        .PAT_NUM   (PAT_NUM),
        .SO        (SO),
`ifdef SCAN_UNLOAD_MISR_COMPARE_EN
        .EXP_SIG   (EXP_SIG),
        .PASS      (PASS),
`endif
        .SE        (SE),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .SIGNATURE (SIGNATURE)
    );

    always #5 CK = ~CK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one unload; cycle k=1 is the first cycle after the START edge.
    // so_seq bit j is driven on the j-th SE-high cycle; glitch pulses START in SHIFT and in DONE.
    task automatic unload(input logic [7:0] pat, input logic [15:0] so_seq, input bit glitch,
                          output int dcyc, output int bcyc, output logic [31:0] trace,
                          output logic pfirst, output logic pdone);
        int idx;
        idx    = 0;
        dcyc   = -1;
        bcyc   = 0;
        trace  = 32'd0;
        pfirst = 1'b0;
        pdone  = 1'b0;
        @(negedge CK);
        START   = 1'b1;
        PAT_NUM = pat;
        @(negedge CK);
        START = 1'b0;
        for (int k = 1; k <= 40; k++) begin
`ifdef SCAN_UNLOAD_MISR_COMPARE_EN
            if (k == 1) pfirst = PASS;
`endif
            if (k <= 32) trace[k-1] = SE;
            bcyc += int'(BUSY);
            if (DONE) begin
                dcyc  = k;
`ifdef SCAN_UNLOAD_MISR_COMPARE_EN
                pdone = PASS;
`endif
                START = glitch;
                break;
            end
            if (SE && idx < 16) begin
                SO  = so_seq[idx];
                idx++;
            end else begin
                SO = 1'b1;
            end
            START = glitch && (k == 2);
            @(negedge CK);
        end
    endtask

    initial begin
        RESETN  = 1'b0;
        START   = 1'b0;
        PAT_NUM = 8'd0;
        SO      = 1'b0;
`ifdef SCAN_UNLOAD_MISR_COMPARE_EN
        EXP_SIG = 4'h0;
`endif
        repeat (2) @(negedge CK);
        check("rst_se",   32'(SE),        32'd0);
        check("rst_busy", 32'(BUSY),      32'd0);
        check("rst_done", 32'(DONE),      32'd0);
        check("rst_sig",  32'(SIGNATURE), 32'h0);
`ifdef SCAN_UNLOAD_MISR_COMPARE_EN
        check("rst_pass", 32'(PASS),      32'd0);
`endif
        RESETN = 1'b1;
        @(negedge CK);

        // Scenario 1: one pattern, SO = 1,0,1,1 -> 4'hB
        unload(8'd1, 16'h000D, 1'b0, done_cyc, busy_cyc, se_trace, pass_first, pass_done);
        check("s1_done_cyc", 32'(done_cyc),  32'd5);
        check("s1_busy_cyc", 32'(busy_cyc),  32'd4);
        check("s1_se_trace", se_trace,       32'h0000000F);
        check("s1_sig",      32'(SIGNATURE), 32'hB);
        @(negedge CK);
        check("s1_done_pulse", 32'(DONE),      32'd0);
        check("s1_sig_hold",   32'(SIGNATURE), 32'hB);

        // Scenario 2: two patterns, SO = 1,0,1,1 then 0,1,1,0 -> 4'h8
        unload(8'd2, 16'h006D, 1'b0, done_cyc, busy_cyc, se_trace, pass_first, pass_done);
        check("s2_done_cyc", 32'(done_cyc),  32'd10);
        check("s2_busy_cyc", 32'(busy_cyc),  32'd9);
        check("s2_se_trace", se_trace,       32'h000001EF);
        check("s2_sig",      32'(SIGNATURE), 32'h8);
        @(negedge CK);

        // Scenario 3: zero patterns -> immediate DONE, signature back to seed
        unload(8'd0, 16'h0000, 1'b0, done_cyc, busy_cyc, se_trace, pass_first, pass_done);
        check("s3_done_cyc", 32'(done_cyc),  32'd1);
        check("s3_busy_cyc", 32'(busy_cyc),  32'd0);
        check("s3_se_trace", se_trace,       32'h0);
        check("s3_sig",      32'(SIGNATURE), 32'h0);
        @(negedge CK);

        // Scenario 4: reset in the third SHIFT cycle aborts immediately
        START   = 1'b1;
        PAT_NUM = 8'd2;
        @(negedge CK);
        START = 1'b0;
        SO    = 1'b1;
        @(negedge CK);
        SO = 1'b1;
        @(negedge CK);
        check("s4_se_pre",  32'(SE),        32'd1);
        check("s4_sig_pre", 32'(SIGNATURE), 32'h3);
        RESETN = 1'b0;
        #1;
        check("s4_se",   32'(SE),        32'd0);
        check("s4_busy", 32'(BUSY),      32'd0);
        check("s4_done", 32'(DONE),      32'd0);
        check("s4_sig",  32'(SIGNATURE), 32'h0);
        @(negedge CK);
        RESETN = 1'b1;
        @(negedge CK);
        unload(8'd1, 16'h000D, 1'b0, done_cyc, busy_cyc, se_trace, pass_first, pass_done);
        check("s4_re_done_cyc", 32'(done_cyc),  32'd5);
        check("s4_re_sig",      32'(SIGNATURE), 32'hB);
        @(negedge CK);

        // Scenario 5: START pulses in SHIFT and in DONE are ignored
        unload(8'd2, 16'h006D, 1'b1, done_cyc, busy_cyc, se_trace, pass_first, pass_done);
        check("s5_done_cyc", 32'(done_cyc),  32'd10);
        check("s5_busy_cyc", 32'(busy_cyc),  32'd9);
        check("s5_se_trace", se_trace,       32'h000001EF);
        check("s5_sig",      32'(SIGNATURE), 32'h8);
        @(negedge CK);
        START = 1'b0;
        check("s5_idle_se",   32'(SE),        32'd0);
        check("s5_idle_busy", 32'(BUSY),      32'd0);
        check("s5_sig_hold",  32'(SIGNATURE), 32'h8);
        @(negedge CK);

`ifdef SCAN_UNLOAD_MISR_COMPARE_EN
        // Scenario 6: comparator against expected signature
        EXP_SIG = 4'hB;
        unload(8'd1, 16'h000D, 1'b0, done_cyc, busy_cyc, se_trace, pass_first, pass_done);
        check("s6_pass_match", 32'(pass_done), 32'd1);
        @(negedge CK);
        check("s6_pass_hold",  32'(PASS),      32'd1);
        EXP_SIG = 4'hA;
        unload(8'd1, 16'h000D, 1'b0, done_cyc, busy_cyc, se_trace, pass_first, pass_done);
        check("s6_pass_clear", 32'(pass_first), 32'd0);
        check("s6_pass_miss",  32'(pass_done),  32'd0);
        @(negedge CK);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_scan_unload_misr
